// File: rtl/snowbro2_eeprom_if.sv
// Serial (Microwire) and host-port signal bundle for the 93C46-style NVRAM.
// The master side is the CPU latch plus NVRAM loader; the slave side is the EEPROM.
interface snowbro2_eeprom_if #(
  parameter int ADDR_W = 6
);
  logic              EEPROM_SCS;
  logic              EEPROM_SCLK;
  logic              EEPROM_SDI;
  logic              EEPROM_SDO;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [15:0]       HOST_DIN;
  logic              HOST_WE;
  logic [15:0]       HOST_DOUT;
  logic              BUSY;

  modport master (
    output EEPROM_SCS, EEPROM_SCLK, EEPROM_SDI, HOST_ADDR, HOST_DIN, HOST_WE,
    input  EEPROM_SDO, HOST_DOUT, BUSY
  );

  modport slave (
    input  EEPROM_SCS, EEPROM_SCLK, EEPROM_SDI, HOST_ADDR, HOST_DIN, HOST_WE,
    output EEPROM_SDO, HOST_DOUT, BUSY
  );
endinterface

// File: rtl/snowbro2_eeprom.sv
// 93C46-compatible 64x16 serial EEPROM responder with a host load/save port.
// Serial pins are oversampled by CLK; all serial actions happen on a synchronised SCLK rise.
module snowbro2_eeprom #(
  parameter int ADDR_W       = 6,
  parameter int WRITE_CYCLES = 4800
) (
  input  logic              CLK,
  input  logic              RESET_N,
  snowbro2_eeprom_if.slave  bus
);
  localparam int WORDS = 1 << ADDR_W;
  localparam int PC_W  = $clog2(WRITE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_RD      = 3'd2,
    S_WD      = 3'd3,
    S_WAIT_CS = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_WRITE = 3'd1,
    K_ERASE = 3'd2,
    K_ERAL  = 3'd3,
    K_WRAL  = 3'd4
  } kind_t;

  logic [1:0]        scs_sync_q, sclk_sync_q, sdi_sync_q;
  logic              sclk_prev_q, scs_prev_q;
  logic              scs_s, sdi_s, sclk_rise_s, cs_fall_s;

  state_t            state_q;
  kind_t             kind_q;
  logic              wen_q, full_q, sdo_q, busy_q, bulk_q;
  logic [4:0]        cnt_q;
  logic [ADDR_W:0]   sh_q;
  logic [ADDR_W-1:0] addr_q, bulk_addr_q;
  logic [15:0]       data_q, bulk_data_q, hout_q;
  logic [PC_W-1:0]   prog_cnt_q;

  // Stored inverted so an all-zero power-up state reads back as the erased 0xFFFF image.
  logic [15:0]       mem_n_q [WORDS];

  logic [ADDR_W+1:0] sh_next_s;
  logic [1:0]        op_s, sub_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [15:0]       mem_word_s;
  logic              commit_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [15:0]       mem_wdata_s;

  // Two-flop synchronisers and edge-detect history for the serial pins.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scs_sync_q  <= 2'b00;
      sclk_sync_q <= 2'b00;
      sdi_sync_q  <= 2'b00;
      sclk_prev_q <= 1'b0;
      scs_prev_q  <= 1'b0;
    end else begin
      scs_sync_q  <= {scs_sync_q[0], bus.EEPROM_SCS};
      sclk_sync_q <= {sclk_sync_q[0], bus.EEPROM_SCLK};
      sdi_sync_q  <= {sdi_sync_q[0], bus.EEPROM_SDI};
      sclk_prev_q <= sclk_sync_q[1];
      scs_prev_q  <= scs_sync_q[1];
    end
  end

  assign scs_s       = scs_sync_q[1];
  assign sdi_s       = sdi_sync_q[1];
  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_prev_q;
  assign cs_fall_s   = scs_prev_q & ~scs_s;

  assign sh_next_s  = {sh_q, sdi_s};
  assign op_s       = sh_next_s[ADDR_W+1:ADDR_W];
  assign cmd_addr_s = sh_next_s[ADDR_W-1:0];
  assign sub_s      = cmd_addr_s[ADDR_W-1:ADDR_W-2];
  assign mem_word_s = ~mem_n_q[addr_q];
  assign commit_s   = (state_q == S_WAIT_CS) && cs_fall_s && wen_q && full_q && (kind_q != K_NONE);

  // Single array write port: serial commit, then bulk fill, then host (host only when idle).
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {ADDR_W{1'b0}};
    mem_wdata_s = 16'h0000;
    if (commit_s && (kind_q == K_WRITE || kind_q == K_ERASE)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = addr_q;
      mem_wdata_s = (kind_q == K_WRITE) ? data_q : 16'hFFFF;
    end else if (bulk_q) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = bulk_addr_q;
      mem_wdata_s = bulk_data_q;
    end else if (bus.HOST_WE && !busy_q && !commit_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = bus.HOST_ADDR;
      mem_wdata_s = bus.HOST_DIN;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Array storage (deliberately not reset).
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_n_q[mem_waddr_s] <= ~mem_wdata_s;
    end
  end

  // Registered host read port.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hout_q <= 16'h0000;
    end else begin
      hout_q <= ~mem_n_q[bus.HOST_ADDR];
    end
  end

  // Microwire command FSM with registered SDO and BUSY.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      kind_q      <= K_NONE;
      wen_q       <= 1'b0;
      full_q      <= 1'b0;
      sdo_q       <= 1'b1;
      busy_q      <= 1'b0;
      bulk_q      <= 1'b0;
      cnt_q       <= 5'd0;
      sh_q        <= {(ADDR_W+1){1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      bulk_addr_q <= {ADDR_W{1'b0}};
      data_q      <= 16'h0000;
      bulk_data_q <= 16'h0000;
      prog_cnt_q  <= {PC_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          sdo_q <= 1'b1;
          if (scs_s && sclk_rise_s && sdi_s) begin
            state_q <= S_CMD;
            cnt_q   <= 5'd0;
          end
        end
        S_CMD: begin
          if (!scs_s) begin
            state_q <= S_IDLE;
            sdo_q   <= 1'b1;
          end else if (sclk_rise_s) begin
            sh_q  <= sh_next_s[ADDR_W:0];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'(ADDR_W + 1)) begin
              addr_q <= cmd_addr_s;
              data_q <= 16'h0000;
              cnt_q  <= 5'd0;
              case (op_s)
                2'b10: begin
                  state_q <= S_RD;
                  sdo_q   <= 1'b0;
                  cnt_q   <= 5'd15;
                end
                2'b01: begin
                  state_q <= S_WD;
                  kind_q  <= K_WRITE;
                  full_q  <= 1'b0;
                end
                2'b11: begin
                  state_q <= S_WAIT_CS;
                  kind_q  <= K_ERASE;
                  full_q  <= 1'b1;
                end
                default: begin
                  case (sub_s)
                    2'b11: begin
                      wen_q   <= 1'b1;
                      kind_q  <= K_NONE;
                      state_q <= S_WAIT_CS;
                    end
                    2'b00: begin
                      wen_q   <= 1'b0;
                      kind_q  <= K_NONE;
                      state_q <= S_WAIT_CS;
                    end
                    2'b10: begin
                      kind_q  <= K_ERAL;
                      full_q  <= 1'b1;
                      state_q <= S_WAIT_CS;
                    end
                    default: begin
                      kind_q  <= K_WRAL;
                      full_q  <= 1'b0;
                      state_q <= S_WD;
                    end
                  endcase
                end
              endcase
            end
          end
        end
        S_RD: begin
          if (!scs_s) begin
            state_q <= S_IDLE;
            sdo_q   <= 1'b1;
          end else if (sclk_rise_s) begin
            sdo_q <= mem_word_s[cnt_q[3:0]];
            if (cnt_q == 5'd0) begin
              cnt_q  <= 5'd15;
              addr_q <= addr_q + ADDR_W'(1);
            end else begin
              cnt_q  <= cnt_q - 5'd1;
            end
          end
        end
        S_WD: begin
          if (!scs_s) begin
            state_q <= S_IDLE;
            sdo_q   <= 1'b1;
          end else if (sclk_rise_s) begin
            data_q <= {data_q[14:0], sdi_s};
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              full_q  <= 1'b1;
              state_q <= S_WAIT_CS;
            end
          end
        end
        S_WAIT_CS: begin
          sdo_q <= 1'b1;
          if (commit_s) begin
            state_q    <= S_PROG;
            busy_q     <= 1'b1;
            prog_cnt_q <= PC_W'(WRITE_CYCLES - 1);
            if (kind_q == K_ERAL || kind_q == K_WRAL) begin
              bulk_q      <= 1'b1;
              bulk_addr_q <= {ADDR_W{1'b0}};
              bulk_data_q <= (kind_q == K_ERAL) ? 16'hFFFF : data_q;
            end
          end else if (cs_fall_s) begin
            state_q <= S_IDLE;
          end
        end
        S_PROG: begin
          // Ready/busy status: low while programming and selected.
          sdo_q <= ~scs_s;
          if (bulk_q) begin
            bulk_addr_q <= bulk_addr_q + ADDR_W'(1);
            if (bulk_addr_q == {ADDR_W{1'b1}}) begin
              bulk_q <= 1'b0;
            end
          end
          if (prog_cnt_q == {PC_W{1'b0}}) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            sdo_q   <= 1'b1;
          end else begin
            prog_cnt_q <= prog_cnt_q - PC_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          sdo_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.EEPROM_SDO = sdo_q;
  assign bus.BUSY       = busy_q;
  assign bus.HOST_DOUT  = hout_q;
endmodule

// File: tb/tb_snowbro2_eeprom.sv
// Directed plus randomized bench for snowbro2_eeprom against a word-array reference model.
module tb_snowbro2_eeprom;
  logic clk = 1'b0;
  logic RESET_N;
  always #5 clk = ~clk;

  snowbro2_eeprom_if #(.ADDR_W(6)) bus ();
  snowbro2_eeprom #(.ADDR_W(6), .WRITE_CYCLES(4800)) dut (
    .CLK(clk), .RESET_N(RESET_N), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] model [64];
  bit wen_m;

  int busy_run = 0;
  int last_busy_len = 0;
  bit busy_seen = 0;

  always @(negedge clk) begin
    if (bus.BUSY === 1'b1) begin
      busy_run++;
      busy_seen = 1'b1;
    end else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic so);
    bus.EEPROM_SDI = b;
    repeat (2) @(negedge clk);
    bus.EEPROM_SCLK = 1'b1;
    repeat (5) @(negedge clk);
    so = bus.EEPROM_SDO;
    bus.EEPROM_SCLK = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_up();
    bus.EEPROM_SCS = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, output logic last_so);
    logic so;
    bit_xfer(1'b1, so);
    bit_xfer(op[1], so);
    bit_xfer(op[0], so);
    for (int i = 5; i >= 0; i--) bit_xfer(a[i], so);
    last_so = so;
  endtask

  task automatic wait_busy(input logic level);
    int t = 0;
    while (bus.BUSY !== level && t < 6000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic finish_cmd(input bit exp_commit, input string tag);
    busy_seen = 1'b0;
    bus.EEPROM_SCS = 1'b0;
    if (exp_commit) begin
      wait_busy(1'b1);
      check({tag, " busy rise"}, 32'(bus.BUSY), 32'd1);
      cs_up();
      repeat (5) @(negedge clk);
      check({tag, " sdo busy"}, 32'(bus.EEPROM_SDO), 32'd0);
      bus.EEPROM_SCS = 1'b0;
      wait_busy(1'b0);
      repeat (2) @(negedge clk);
      check({tag, " busy fall"}, 32'(bus.BUSY), 32'd0);
      check({tag, " busy len"}, 32'(last_busy_len), 32'd4800);
    end else begin
      repeat (30) @(negedge clk);
      check({tag, " no busy"}, 32'(busy_seen), 32'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, " sdo idle"}, 32'(bus.EEPROM_SDO), 32'd1);
  endtask

  task automatic set_wen(input bit on);
    logic so;
    cs_up();
    send_cmd(2'b00, on ? 6'b110000 : 6'b000000, so);
    wen_m = on;
    finish_cmd(1'b0, on ? "ewen" : "ewds");
  endtask

  task automatic serial_write(input logic [5:0] a, input logic [15:0] d, input int nbits, input string tag);
    logic so;
    bit commit;
    commit = wen_m && (nbits >= 16);
    cs_up();
    send_cmd(2'b01, a, so);
    for (int i = 0; i < nbits; i++) bit_xfer(d[15-i], so);
    if (commit) model[a] = d;
    finish_cmd(commit, tag);
  endtask

  task automatic serial_erase(input logic [5:0] a);
    logic so;
    cs_up();
    send_cmd(2'b11, a, so);
    if (wen_m) model[a] = 16'hFFFF;
    finish_cmd(wen_m, "erase");
  endtask

  task automatic serial_read(input logic [5:0] a, input int nwords, input string tag);
    logic so;
    logic [15:0] got;
    cs_up();
    send_cmd(2'b10, a, so);
    check({tag, " dummy"}, 32'(so), 32'd0);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 15; b >= 0; b--) begin
        bit_xfer(1'b0, so);
        got[b] = so;
      end
      check({tag, " word"}, 32'(got), 32'(model[(int'(a) + w) % 64]));
    end
    bus.EEPROM_SCS = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, " sdo deselect"}, 32'(bus.EEPROM_SDO), 32'd1);
  endtask

  task automatic host_read(input logic [5:0] a, input string tag);
    bus.HOST_ADDR = a;
    @(negedge clk);
    check(tag, 32'(bus.HOST_DOUT), 32'(model[a]));
  endtask

  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    bus.HOST_ADDR = a;
    bus.HOST_DIN = d;
    bus.HOST_WE = 1'b1;
    if (bus.BUSY === 1'b0) model[a] = d;
    @(negedge clk);
    bus.HOST_WE = 1'b0;
  endtask

  initial begin
    logic so;
    logic [5:0] ra;
    logic [15:0] rd;
    for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
    wen_m = 1'b0;
    bus.EEPROM_SCS = 1'b0;
    bus.EEPROM_SCLK = 1'b0;
    bus.EEPROM_SDI = 1'b0;
    bus.HOST_ADDR = 6'd0;
    bus.HOST_DIN = 16'h0000;
    bus.HOST_WE = 1'b0;
    RESET_N = 1'b0;
    repeat (5) @(negedge clk);
    check("reset sdo", 32'(bus.EEPROM_SDO), 32'd1);
    check("reset busy", 32'(bus.BUSY), 32'd0);
    check("reset hout", 32'(bus.HOST_DOUT), 32'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge clk);

    serial_read(6'd0, 1, "read0 erased");
    serial_write(6'd5, 16'h1234, 16, "write no ewen");
    serial_read(6'd5, 1, "read5 unchanged");

    set_wen(1'b1);
    serial_write(6'd5, 16'h1234, 16, "write5");
    serial_read(6'd5, 1, "read5");
    host_read(6'd5, "host5");

    set_wen(1'b0);
    serial_write(6'd5, 16'hAAAA, 16, "write after ewds");
    serial_read(6'd5, 1, "read5 after ewds");

    for (int k = 0; k < 3; k++) begin
      ra = 6'($urandom_range(1, 62));
      rd = 16'($urandom);
      set_wen(bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) serial_erase(ra);
      else serial_write(ra, rd, 16, "rand write");
      serial_read(ra, 1, "rand read");
    end

    set_wen(1'b1);
    serial_write(6'd63, 16'($urandom), 16, "write63");
    serial_write(6'd0, 16'($urandom), 16, "write0");
    serial_read(6'd63, 2, "seq read wrap");
    host_read(6'd63, "host63");
    host_read(6'd0, "host0");

    serial_write(6'd7, 16'h5A5A, 8, "partial write");
    serial_read(6'd7, 1, "read7 after partial");

    // Host write attempted while a serial program is busy.
    cs_up();
    send_cmd(2'b01, 6'd12, so);
    rd = 16'($urandom);
    for (int i = 0; i < 16; i++) bit_xfer(rd[15-i], so);
    model[12] = rd;
    bus.EEPROM_SCS = 1'b0;
    wait_busy(1'b1);
    check("prog12 busy", 32'(bus.BUSY), 32'd1);
    host_write(6'd20, 16'h5555);
    wait_busy(1'b0);
    repeat (2) @(negedge clk);
    host_read(6'd20, "host20 dropped");
    host_read(6'd12, "host12");

    host_write(6'd9, 16'hBEEF);
    repeat (2) @(negedge clk);
    serial_read(6'd9, 1, "read9 host written");

    cs_up();
    send_cmd(2'b00, 6'b100000, so);
    for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
    finish_cmd(1'b1, "eral");
    for (int i = 0; i < 64; i++) host_read(6'(i), "eral word");

    cs_up();
    send_cmd(2'b00, 6'b010000, so);
    rd = 16'($urandom);
    for (int i = 0; i < 16; i++) bit_xfer(rd[15-i], so);
    for (int i = 0; i < 64; i++) model[i] = rd;
    finish_cmd(1'b1, "wral");
    for (int i = 0; i < 64; i++) host_read(6'(i), "wral word");

    // Reset pulse in the middle of programming.
    cs_up();
    send_cmd(2'b01, 6'd30, so);
    rd = 16'($urandom);
    for (int i = 0; i < 16; i++) bit_xfer(rd[15-i], so);
    model[30] = rd;
    bus.EEPROM_SCS = 1'b0;
    wait_busy(1'b1);
    check("prog30 busy", 32'(bus.BUSY), 32'd1);
    repeat (100) @(negedge clk);
    RESET_N = 1'b0;
    #1;
    check("midprog reset busy", 32'(bus.BUSY), 32'd0);
    check("midprog reset sdo", 32'(bus.EEPROM_SDO), 32'd1);
    wen_m = 1'b0;
    repeat (3) @(negedge clk);
    RESET_N = 1'b1;
    repeat (3) @(negedge clk);
    serial_write(6'd31, 16'h0F0F, 16, "write after reset");
    serial_read(6'd30, 2, "read30-31 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snowbro2_eeprom.md
Name: snowbro2_eeprom

Overview:
- Serial EEPROM responder: a 93C46-compatible 64x16 NVRAM model.
- It is the far end of the EEPROM_SCS/SCLK/SDI/SDO interface driven by the 68K I/O latch in snowbro2_cpu.
- It decodes the Microwire command stream and services READ/WRITE/ERASE/EWEN/EWDS/ERAL/WRAL.
- A host port lets the MiSTer NVRAM load/save logic read and write contents.

Parameters:
- ADDR_W, 6, word address width (64 words).
- WRITE_CYCLES, 4800, CLK cycles of self-timed programming busy (100 us at 48 MHz).

Ports:
- CLK  in  1  system clock (48 MHz)
- RESET_N  in  1  asynchronous, active-low reset
- EEPROM_SCS  in  1  chip select, active high
- EEPROM_SCLK  in  1  serial clock from CPU latch (asynchronous to CLK, slow)
- EEPROM_SDI  in  1  serial data into EEPROM
- EEPROM_SDO  out  1  serial data / ready-busy out
- HOST_ADDR  in  ADDR_W  host word address
- HOST_DIN  in  16  host write data
- HOST_WE  in  1  host write strobe, one word per cycle
- HOST_DOUT  out  16  host read data, registered, 1-cycle latency
- BUSY  out  1  high during programming

Behaviour:
- SCS, SCLK and SDI pass through 2-flop synchronisers. SCLK rising edge = sclk_rise pulse; SCS falling edge = cs_fall pulse. All serial actions occur on sclk_rise, so effective latency is 3 CLK after the pin edge.
- Reset values: EEPROM_SDO=1, BUSY=0, HOST_DOUT=0, state IDLE, write-enable latch WEN=0, bit counter 0. Array contents are not reset; the power-up image is 0xFFFF.
- IDLE: with SCS high, sclk_rise with SDI=1 is the start bit → CMD. SDI=0 (leading zeros) is ignored.
- CMD: shift 2 opcode + ADDR_W address bits, MSB first. On the last bit, decode:
  - 10 READ → RD. SDO=0 dummy bit driven on that same sclk_rise.
  - 01 WRITE → WD.
  - 11 ERASE → WAIT_CS.
  - 00 with addr[5:4]: 11 EWEN (WEN=1) and 00 EWDS (WEN=0) → WAIT_CS with no programming; 10 ERAL → WAIT_CS; 01 WRAL → WD.
- RD: each sclk_rise shifts the next bit of mem[addr] onto SDO, MSB first. After bit 0, addr increments (63 wraps to 0) and output continues with the new word (sequential read). This continues until SCS falls.
- WD: shifts 16 data bits. Extra bits beyond 16 are ignored. Then → WAIT_CS.
- WAIT_CS: on cs_fall, commit if WEN=1 and the command had its full 16 data bits:
  - WRITE: mem[addr]=data.
  - ERASE: mem[addr]=0xFFFF.
  - ERAL: all words = 0xFFFF.
  - WRAL: all words = data (64 cycles internally, within the busy window).
  - Commit → PROG. No commit → IDLE.
- PROG: BUSY=1 for exactly WRITE_CYCLES CLK, then → IDLE. While SCS is high, SDO=0 when busy and 1 when ready. Start bits received during PROG are ignored.
- SCS low in any state other than WAIT_CS/PROG aborts to IDLE with no array change; SDO returns to 1.
- SDO=1 whenever SCS is low or in IDLE.
- Host port:
  - HOST_DOUT = mem[HOST_ADDR] registered.
  - HOST_WE is honoured only when BUSY=0 and no serial commit occurs in the same cycle; otherwise it is dropped (serial wins).
- Reset mid-operation: state returns to IDLE and WEN=0. A partial ERAL/WRAL may leave the array mixed; this is acceptable.

Test Plan:
- Reset, SCS low → SDO=1, BUSY=0; READ addr 0 returns 0xFFFF preceded by a 0 dummy bit.
- EWEN (1 00 11xxxx), then WRITE addr 5 data 0x1234, drop SCS → BUSY high for 4800 CLK and SDO=0 while SCS high. Then READ addr 5 → 0x1234.
- Write without EWEN (after reset or after EWDS) to addr 5 → array unchanged, BUSY stays 0.
- Sequential READ from addr 63 for 32 clocks → mem[63] then mem[0]; HOST_DOUT matches both via the host port.
- SCS drops after 8 of 16 WRITE data bits → no change, back to IDLE. ERAL with WEN=1 → all 64 words 0xFFFF.
- HOST_WE during PROG → ignored. HOST_WE while idle addr 9 = 0xBEEF → serial READ 9 returns 0xBEEF. RESET_N pulse mid-PROG → BUSY=0 and WEN=0 immediately.
